// File: rtl/btn_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// btn_cmd_arbiter
//
// Turns 1-cycle press pulses from a bank of debouncers into one ordered stream
// of button-index commands for the microwave control FSM.
//
// Two stages:
//   1. Pending register: one bit per button. Each cycle the lowest-index set
//      bit (highest priority) moves into the FIFO if there is room. A press
//      that lands on a button which is already pending, and is not moving out
//      this cycle, merges into the pending bit and is counted as dropped.
//   2. Command FIFO: DEPTH entries of button indices. A pop in the same cycle
//      does not create room for a push; fullness is judged on the pre-pop
//      count.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   i_clear      synchronous flush of pending bits and FIFO (drop count kept)
//   i_btn        debounced press pulses, bit k = button k
//   i_cmd_ready  consumer accepts the head command this cycle
//   o_cmd_valid  FIFO non-empty, o_cmd_id is valid
//   o_cmd_id     button index of the head command
//   o_pending    presses latched but not yet in the FIFO
//   o_full       FIFO holds DEPTH entries
//   o_drop_cnt   presses lost to merging, saturating
// -----------------------------------------------------------------------------
module btn_cmd_arbiter #(
    parameter  int N_BTN  = 5,
    parameter  int DEPTH  = 4,
    parameter  int DROP_W = 8,
    localparam int ID_W   = $clog2(N_BTN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic [N_BTN-1:0]  i_btn,
    input  logic              i_cmd_ready,
    output logic              o_cmd_valid,
    output logic [ID_W-1:0]   o_cmd_id,
    output logic [N_BTN-1:0]  o_pending,
    output logic              o_full,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough to hold the drop count plus one cycle's worth of merges
    // before saturating.
    localparam int SUM_W = DROP_W + ID_W + 1;
    localparam logic [SUM_W-1:0] DROP_MAX = {{(SUM_W-DROP_W){1'b0}}, {DROP_W{1'b1}}};

    logic [N_BTN-1:0]  pend;
    logic [ID_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DROP_W-1:0] drop_cnt;

    logic [ID_W-1:0]   sel;
    logic              push;
    logic              pop;
    logic [N_BTN-1:0]  push_mask;
    logic [N_BTN-1:0]  pend_next;
    logic [N_BTN-1:0]  drop_bits;
    logic [SUM_W-1:0]  drop_inc;
    logic [SUM_W-1:0]  drop_sum;
    logic [DROP_W-1:0] drop_next;
    logic [CNT_W-1:0]  count_next;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel        = '0;
        push_mask  = '0;
        drop_inc   = '0;
        count_next = count;

        // Scan from the top down so the last hit is the lowest set index.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = ID_W'(i);
            end
        end

        // Fullness uses the pre-pop count: a same-cycle pop frees nothing.
        push = (pend != '0) && (count < CNT_W'(DEPTH));
        pop  = (count != '0) && i_cmd_ready;

        if (push) begin
            push_mask = N_BTN'(1) << sel;
        end

        // A press on the bit being pushed re-arms it as a fresh event.
        pend_next = (pend & ~push_mask) | i_btn;
        drop_bits = i_btn & pend & ~push_mask;

        for (int i = 0; i < N_BTN; i++) begin
            drop_inc = drop_inc + SUM_W'(drop_bits[i]);
        end
        drop_sum  = SUM_W'(drop_cnt) + drop_inc;
        drop_next = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            // NOTE: the storage array is reset too; it is only a few flops and
            // o_cmd_id must read zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_clear) begin
            // Flush wins over any push, pop or press in the same cycle.
            pend   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            pend     <= pend_next;
            count    <= count_next;
            drop_cnt <= drop_next;
            if (push) begin
                mem[wr_ptr] <= sel;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_cmd_valid = (count != '0);
    assign o_cmd_id    = mem[rd_ptr];
    assign o_pending   = pend;
    assign o_full      = (count == CNT_W'(DEPTH));
    assign o_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_btn_cmd_arbiter
//
// Directed bench for btn_cmd_arbiter (N_BTN=5, DEPTH=4, DROP_W=8). Inputs are
// driven 1 ns after the rising edge and outputs are checked at the same
// point, i.e. they show the state loaded by the edge just passed.
// -----------------------------------------------------------------------------
module tb_btn_cmd_arbiter;

    localparam int N_BTN  = 5;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int ID_W   = $clog2(N_BTN);

    logic              clk;
    logic              rst;
    logic              i_clear;
    logic [N_BTN-1:0]  i_btn;
    logic              i_cmd_ready;
    logic              o_cmd_valid;
    logic [ID_W-1:0]   o_cmd_id;
    logic [N_BTN-1:0]  o_pending;
    logic              o_full;
    logic [DROP_W-1:0] o_drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    btn_cmd_arbiter #(
        .N_BTN  (N_BTN),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (i_clear),
        .i_btn       (i_btn),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_id    (o_cmd_id),
        .o_pending   (o_pending),
        .o_full      (o_full),
        .o_drop_cnt  (o_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one button pattern for a cycle, then return i_btn to zero.
    task automatic press(input logic [N_BTN-1:0] b);
        i_btn = b;
        tick();
        i_btn = '0;
    endtask

    // Drain with ready held high; ids are packed 3 bits each, first id in the
    // low bits. After n commands the FIFO must be empty.
    task automatic drain(input string tag, input int n, input logic [14:0] ids);
        i_cmd_ready = 1'b1;
        i_btn       = '0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), 32'(o_cmd_valid), 32'd1);
            check($sformatf("%s id[%0d]", tag, i), 32'(o_cmd_id), 32'(ids[3*i +: 3]));
            tick();
        end
        check($sformatf("%s empty", tag), 32'(o_cmd_valid), 32'd0);
        i_cmd_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        i_clear     = 1'b0;
        i_btn       = '0;
        i_cmd_ready = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst valid",   32'(o_cmd_valid), 32'd0);
        check("rst id",      32'(o_cmd_id),    32'd0);
        check("rst pending", 32'(o_pending),   32'd0);
        check("rst full",    32'(o_full),      32'd0);
        check("rst drop",    32'(o_drop_cnt),  32'd0);
        rst = 1'b0;
        tick();

        // ---------------- T1 single press ----------------
        i_cmd_ready = 1'b1;
        press(5'b00100);
        check("t1 pend E0",  32'(o_pending),   32'b00100);
        check("t1 valid E0", 32'(o_cmd_valid), 32'd0);
        tick();
        check("t1 valid E1", 32'(o_cmd_valid), 32'd1);
        check("t1 id E1",    32'(o_cmd_id),    32'd2);
        check("t1 pend E1",  32'(o_pending),   32'd0);
        tick();
        check("t1 valid E2", 32'(o_cmd_valid), 32'd0);
        tick();   // ready high while empty must be harmless
        check("t1 idle",     32'(o_cmd_valid), 32'd0);

        // ---------------- T2 simultaneous ----------------
        press(5'b10101);
        check("t2 pend0",  32'(o_pending),   32'b10101);
        check("t2 valid0", 32'(o_cmd_valid), 32'd0);
        tick();
        check("t2 id a",   32'(o_cmd_id),    32'd0);
        check("t2 pend a", 32'(o_pending),   32'b10100);
        tick();
        check("t2 id b",   32'(o_cmd_id),    32'd2);
        check("t2 pend b", 32'(o_pending),   32'b10000);
        tick();
        check("t2 id c",   32'(o_cmd_id),    32'd4);
        check("t2 pend c", 32'(o_pending),   32'd0);
        tick();
        check("t2 empty",  32'(o_cmd_valid), 32'd0);

        // ---------------- T3 backpressure ----------------
        i_cmd_ready = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            press(N_BTN'(1) << k);
        end
        tick();
        check("t3 full",    32'(o_full),      32'd1);
        check("t3 pending", 32'(o_pending),   32'b10000);
        check("t3 valid",   32'(o_cmd_valid), 32'd1);
        check("t3 head",    32'(o_cmd_id),    32'd0);
        drain("t3 drain", 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        check("t3 full after", 32'(o_full), 32'd0);

        // ---------------- T4 merge / drop ----------------
        for (int k = 0; k < DEPTH; k++) begin
            press(N_BTN'(1) << k);
        end
        tick();
        check("t4 full", 32'(o_full), 32'd1);
        press(5'b10000);
        check("t4 no drop first", 32'(o_drop_cnt), 32'd0);
        press(5'b10000);
        tick();
        check("t4 drop1",   32'(o_drop_cnt), 32'd1);
        check("t4 pending", 32'(o_pending),  32'b10000);
        drain("t4 drain", 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        check("t4 pend after", 32'(o_pending),  32'd0);
        check("t4 drop kept",  32'(o_drop_cnt), 32'd1);

        // ---------------- T5a push+pop together at count=2 ----------------
        press(5'b00011);
        tick();
        tick();
        check("t5 pend empty", 32'(o_pending), 32'd0);
        check("t5 head0",      32'(o_cmd_id),  32'd0);
        press(5'b00100);          // pend=00100, count still 2
        check("t5 full no",    32'(o_full),    32'd0);
        i_cmd_ready = 1'b1;
        tick();                   // pop id0 and push id2 in one edge
        check("t5 pend moved", 32'(o_pending), 32'd0);
        drain("t5 pp", 2, {3'd0, 3'd0, 3'd0, 3'd2, 3'd1});

        // ---------------- T5b press while own bit is pushed ----------------
        press(5'b01000);
        press(5'b01000);          // bit 3 pushed this edge and re-armed
        check("t5b pend rearm", 32'(o_pending), 32'b01000);
        tick();
        check("t5b drop same",  32'(o_drop_cnt), 32'd1);
        check("t5b pend none",  32'(o_pending),  32'd0);
        drain("t5b", 2, {3'd0, 3'd0, 3'd0, 3'd3, 3'd3});

        // ---------------- T4b saturation ----------------
        for (int k = 0; k < DEPTH; k++) begin
            press(N_BTN'(1) << k);
        end
        tick();
        i_btn = 5'b10000;
        for (int k = 0; k < 301; k++) begin   // 1 arm + 300 merges
            tick();
        end
        i_btn = '0;
        check("t4b drop sat", 32'(o_drop_cnt), 32'd255);
        drain("t4b drain", 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});

        // ---------------- T6 synchronous clear ----------------
        press(5'b00111);
        tick();
        tick();
        check("t6 pre valid", 32'(o_cmd_valid), 32'd1);
        check("t6 pre pend",  32'(o_pending),   32'b00100);
        i_clear     = 1'b1;
        i_cmd_ready = 1'b1;
        i_btn       = 5'b10000;
        tick();
        i_clear     = 1'b0;
        i_cmd_ready = 1'b0;
        i_btn       = '0;
        check("t6 clr valid", 32'(o_cmd_valid), 32'd0);
        check("t6 clr pend",  32'(o_pending),   32'd0);
        check("t6 clr full",  32'(o_full),      32'd0);
        check("t6 clr drop",  32'(o_drop_cnt),  32'd255);
        tick();
        check("t6 btn gone",  32'(o_cmd_valid), 32'd0);
        // Pointers restart at zero: a fresh press comes out normally.
        press(5'b00010);
        tick();
        check("t6 post id",   32'(o_cmd_id),    32'd1);

        // ---------------- T6 asynchronous reset ----------------
        press(5'b00110);          // queue now holds 1 + two more to come
        tick();
        tick();
        check("t6 q valid", 32'(o_cmd_valid), 32'd1);
        check("t6 q full",  32'(o_full),      32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst valid",   32'(o_cmd_valid), 32'd0);
        check("arst id",      32'(o_cmd_id),    32'd0);
        check("arst pending", 32'(o_pending),   32'd0);
        check("arst drop",    32'(o_drop_cnt),  32'd0);
        check("arst full",    32'(o_full),      32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("arst stays", 32'(o_cmd_valid), 32'd0);

        // Normal operation after reset.
        i_cmd_ready = 1'b1;
        press(5'b01000);
        tick();
        check("post rst id",    32'(o_cmd_id),    32'd3);
        check("post rst valid", 32'(o_cmd_valid), 32'd1);
        tick();
        check("post rst empty", 32'(o_cmd_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
